uart_step_ctrl: RTL and testbench

Debug sequencer that owns the core step clock and the FTDI UART transmit path. It takes single-byte commands from the UART receiver. It can single-step the core, step it N times, free-run it, or halt it. It returns a 16-bit probe value (e.g. ALU register a) as two bytes, low byte first. It sits in top between the uart instance and the control/alu/ram step clock, and replaces the ad-hoc test state machine.

---
 rtl/uart_step_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_step_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_step_ctrl.sv
// uart_step_ctrl: debug sequencer for the core step clock and the UART TX path.
//
// Takes single-byte commands from the UART receiver:
//   's' 0x73  one step, then dump the probe
//   'd' 0x64  dump the probe only
//   'n' 0x6E  next byte is a step count N; N steps, then dump (N=0: dump only)
//   'r' 0x72  free-run, one step every 2^RUN_SHIFT CLK cycles
//   'h' 0x68  leave free-run (no-op when idle)
// A dump sends the 16-bit probe as two bytes, low byte first.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous, active-high reset
//   RXbuffer   received byte, valid while RXready=1
//   RXready    one-cycle pulse, new byte available
//   TXbusy     UART transmitter busy
//   probe      value returned on a dump (must be 16 bits wide)
//   TXbuffer   byte to transmit; holds its value between transmissions
//   TXstart    one-cycle transmit request
//   stepClock  core clock; idles high, low for exactly one CLK cycle per step
//   halted     1 in every state except RUN
//
// All outputs are registered.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | waiting for a command byte
// GET_N        | waiting for the step count byte (any value accepted)
// STEP_LO      | stepClock low for one cycle, step counter decrements
// STEP_HI      | stepClock high settle cycle; more steps or go sample
// SAMPLE       | probe captured on entry; low byte may be requested here
// TX_LO        | low byte request pulse / waiting for TXbusy=0
// TX_LO_GUARD  | one cycle with TXbusy ignored (UART busy-assert latency)
// TX_HI        | high byte request pulse / waiting for TXbusy=0
// TX_HI_GUARD  | one cycle with TXbusy ignored, then back to IDLE
// RUN          | free-running steps from the run divider

module uart_step_ctrl #(
  parameter int unsigned RUN_SHIFT = 4,
  parameter int unsigned PROBE_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [7:0]         RXbuffer,
  input  logic               RXready,
  input  logic               TXbusy,
  input  logic [PROBE_W-1:0] probe,
  output logic [7:0]         TXbuffer,
  output logic               TXstart,
  output logic               stepClock,
  output logic               halted
);

  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_DUMP  = 8'h64;
  localparam logic [7:0] CMD_COUNT = 8'h6E;
  localparam logic [7:0] CMD_RUN   = 8'h72;
  localparam logic [7:0] CMD_HALT  = 8'h68;

  // A zero-width divider is not legal, so RUN_SHIFT=0 keeps one bit that
  // never leaves zero: a step is then due on every cycle.
  localparam int unsigned      DIV_W   = (RUN_SHIFT == 0) ? 1 : RUN_SHIFT;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((1 << RUN_SHIFT) - 1);

  typedef enum logic [3:0] {
    IDLE,
    GET_N,
    STEP_LO,
    STEP_HI,
    SAMPLE,
    TX_LO,
    TX_LO_GUARD,
    TX_HI,
    TX_HI_GUARD,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PROBE_W-1:0] lat_q, lat_d;
  logic [7:0]         txbuf_q, txbuf_d;
  logic               txstart_q, txstart_d;
  logic               step_clk_q, step_clk_d;
  logic               halted_q, halted_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    lat_d      = lat_q;
    txbuf_d    = txbuf_q;
    txstart_d  = 1'b0;
    step_clk_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (RXready) begin
          case (RXbuffer)
            CMD_STEP: begin
              cnt_d   = 8'd1;
              state_d = STEP_LO;
            end
            CMD_DUMP:  state_d = SAMPLE;
            CMD_COUNT: state_d = GET_N;
            CMD_RUN: begin
              div_d   = '0;
              state_d = RUN;
            end
            default: ;
          endcase
        end
      end

      GET_N: begin
        if (RXready) begin
          cnt_d   = RXbuffer;
          state_d = (RXbuffer == 8'd0) ? SAMPLE : STEP_LO;
        end
      end

      STEP_LO: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = STEP_HI;
      end

      STEP_HI: state_d = (cnt_q != 8'd0) ? STEP_LO : SAMPLE;

      // The low byte request is decided here so it is on the wire during the
      // first TX_LO cycle when the UART is already free.
      SAMPLE: begin
        state_d = TX_LO;
        if (!TXbusy) begin
          txstart_d = 1'b1;
          txbuf_d   = lat_q[7:0];
        end
      end

      // txstart_q set means the request went out this cycle; otherwise keep
      // waiting and raise it the cycle after TXbusy is seen low.
      TX_LO: begin
        if (txstart_q) begin
          state_d = TX_LO_GUARD;
        end else if (!TXbusy) begin
          txstart_d = 1'b1;
          txbuf_d   = lat_q[7:0];
        end
      end

      TX_LO_GUARD: state_d = TX_HI;

      TX_HI: begin
        if (txstart_q) begin
          state_d = TX_HI_GUARD;
        end else if (!TXbusy) begin
          txstart_d = 1'b1;
          txbuf_d   = lat_q[15:8];
        end
      end

      TX_HI_GUARD: state_d = IDLE;

      // A low phase is only ever one cycle, so halting always leaves with
      // stepClock high and never cuts a pulse short. A step that is due in
      // the same cycle as the halt is not issued.
      RUN: begin
        if (RXready && (RXbuffer == CMD_HALT)) begin
          state_d = IDLE;
        end else if (div_q == DIV_MAX) begin
          div_d      = '0;
          // With RUN_SHIFT=0 a step is due every cycle; skipping the cycle
          // after a low phase gives alternating low/high.
          step_clk_d = ~step_clk_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d == STEP_LO) begin
      step_clk_d = 1'b0;
    end

    // SAMPLE is always left after one cycle, so this fires once per dump,
    // one full cycle after the last rising edge of stepClock.
    if (state_d == SAMPLE) begin
      lat_d = probe;
    end

    halted_d = (state_d != RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      div_q      <= '0;
      lat_q      <= '0;
      txbuf_q    <= 8'h00;
      txstart_q  <= 1'b0;
      step_clk_q <= 1'b1;
      halted_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      lat_q      <= lat_d;
      txbuf_q    <= txbuf_d;
      txstart_q  <= txstart_d;
      step_clk_q <= step_clk_d;
      halted_q   <= halted_d;
    end
  end

  assign TXbuffer  = txbuf_q;
  assign TXstart   = txstart_q;
  assign stepClock = step_clk_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_uart_step_ctrl.sv
// Bench for uart_step_ctrl. The probe comes from a model core that counts
// rising edges of stepClock, so a dump must return probe_base plus the number
// of steps the reference model says have happened. Expected step cycles and
// TX bytes are queued when a command is issued; the monitor pops them as the
// DUT produces stepClock low cycles and TXstart pulses.

module tb_uart_step_ctrl;

  localparam int RUN_SHIFT  = 4;
  localparam int RUN_PERIOD = 1 << RUN_SHIFT;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RXbuffer;
  logic        RXready;
  logic        TXbusy;
  logic [15:0] probe;
  logic [7:0]  TXbuffer;
  logic        TXstart;
  logic        stepClock;
  logic        halted;

  uart_step_ctrl #(.RUN_SHIFT(RUN_SHIFT), .PROBE_W(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RXbuffer (RXbuffer),
    .RXready  (RXready),
    .TXbusy   (TXbusy),
    .probe    (probe),
    .TXbuffer (TXbuffer),
    .TXstart  (TXstart),
    .stepClock(stepClock),
    .halted   (halted)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // model core: probe advances on every stepClock rising edge
  logic [15:0] probe_base = 16'h0000;
  int          core_edges = 0;
  always @(posedge stepClock) if (!RST) core_edges <= core_edges + 1;
  assign probe = probe_base + 16'(core_edges);

  // model UART transmitter: busy for 2..9 cycles after each request
  logic uart_busy  = 1'b0;
  logic force_busy = 1'b0;
  logic tx_pending = 1'b0;
  int   busy_left  = 0;
  assign TXbusy = uart_busy | force_busy;

  initial forever begin
    @(posedge CLK);
    #1;
    if (busy_left > 0) busy_left--;
    if (tx_pending) begin
      busy_left  = $urandom_range(2, 9);
      tx_pending = 1'b0;
    end
    uart_busy = (busy_left > 0);
  end

  // scoreboard
  int         exp_step_q[$];
  logic [7:0] exp_tx_q[$];
  int         tx_log[$];
  int         run_from = 32'h7fffffff;
  int         run_to   = 0;
  logic       busy_prev = 1'b0;

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (stepClock !== 1'b1) begin
        if (exp_step_q.size() == 0) check("step_unexpected", 32'(stepClock), 32'd1);
        else check("step_cycle", cyc, exp_step_q.pop_front());
      end
      if (TXstart === 1'b1) begin
        tx_pending = 1'b1;
        tx_log.push_back(cyc);
        check("tx_while_busy", 32'(busy_prev), 32'd0);
        if (exp_tx_q.size() == 0) check("tx_unexpected", 32'(TXstart), 32'd0);
        else check("tx_byte", 32'(TXbuffer), 32'(exp_tx_q.pop_front()));
      end
      check("halted", 32'(halted), (cyc >= run_from && cyc <= run_to) ? 32'd0 : 32'd1);
    end
    busy_prev = TXbusy;
  end

  // reference model state
  int model_steps = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RXbuffer = b;
    RXready  = 1'b1;
    tick();
    RXready  = 1'b0;
  endtask

  task automatic exp_steps(input int first, input int n);
    for (int i = 0; i < n; i++) exp_step_q.push_back(first + 2 * i);
    model_steps += n;
  endtask

  task automatic exp_dump();
    logic [15:0] v;
    v = probe_base + 16'(model_steps);
    exp_tx_q.push_back(v[7:0]);
    exp_tx_q.push_back(v[15:8]);
  endtask

  task automatic do_s();
    exp_steps(cyc + 1, 1);
    exp_dump();
    send_byte(8'h73);
  endtask

  task automatic do_d();
    exp_dump();
    send_byte(8'h64);
  endtask

  task automatic do_n(input logic [7:0] n);
    send_byte(8'h6E);
    exp_steps(cyc + 1, int'(n));
    exp_dump();
    send_byte(n);
  endtask

  // 'r' now, 'h' h_off cycles later; steps fall at c+1+k*RUN_PERIOD, k>=1
  task automatic do_run(input int h_off);
    int c, h_c, p;
    c   = cyc;
    h_c = c + h_off;
    p   = c + 1 + RUN_PERIOD;
    while (p <= h_c) begin
      exp_step_q.push_back(p);
      model_steps++;
      p += RUN_PERIOD;
    end
    run_from = c + 1;
    run_to   = h_c;
    send_byte(8'h72);
    while (cyc < h_c) tick();
    send_byte(8'h68);
    check("halt_stepclk", 32'(stepClock), 32'd1);
    check("halt_halted", 32'(halted), 32'd1);
    repeat (2 * RUN_PERIOD) tick();
    check("run_steps_left", exp_step_q.size(), 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && (exp_step_q.size() + exp_tx_q.size()) != 0; i++) tick();
    check("seq_done", exp_step_q.size() + exp_tx_q.size(), 32'd0);
    repeat (3) tick();
  endtask

  task automatic wait_uart_idle();
    for (int i = 0; i < 50 && TXbusy; i++) tick();
  endtask

  task automatic scenario_s_1234();
    int c;
    wait_uart_idle();
    probe_base = 16'h1234 - 16'(model_steps + 1);
    tx_log.delete();
    c = cyc;
    do_s();
    wait_done();
    check("s_tx_count", tx_log.size(), 32'd2);
    if (tx_log.size() > 0) check("s_tx_latency", tx_log[0], c + 4);
    check("s_idle_halted", 32'(halted), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    logic [7:0] b;
    RST      = 1'b1;
    RXbuffer = 8'h00;
    RXready  = 1'b0;
    #2;
    check("rst_stepclk", 32'(stepClock), 32'd1);
    check("rst_txstart", 32'(TXstart), 32'd0);
    check("rst_txbuf", 32'(TXbuffer), 32'h00);
    check("rst_halted", 32'(halted), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    tick();

    // single step with probe 0x1234
    scenario_s_1234();

    // five steps, probe ends at 0xBEEF
    probe_base = 16'hBEEF - 16'(model_steps + 5);
    do_n(8'd5);
    wait_done();

    // zero count: dump only
    do_n(8'd0);
    wait_done();

    // dump while the UART is held busy for 20 cycles
    wait_uart_idle();
    tx_log.delete();
    force_busy = 1'b1;
    c = cyc;
    do_d();
    while (cyc < c + 20) tick();
    force_busy = 1'b0;
    wait_done();
    check("busy_tx_count", tx_log.size(), 32'd2);
    if (tx_log.size() > 0) check("busy_tx_release", tx_log[0], c + 21);

    // free run, halt coincident with the seventh step pulse
    do_run(1 + 7 * RUN_PERIOD);

    // reset during TX_HI: high byte must never appear
    wait_uart_idle();
    c = cyc;
    exp_steps(c + 1, 1);
    begin
      logic [15:0] v;
      v = probe_base + 16'(model_steps);
      exp_tx_q.push_back(v[7:0]);
    end
    send_byte(8'h73);
    while (cyc < c + 6) tick();
    RST = 1'b1;
    #1;
    check("midrst_stepclk", 32'(stepClock), 32'd1);
    check("midrst_txstart", 32'(TXstart), 32'd0);
    check("midrst_halted", 32'(halted), 32'd1);
    check("midrst_txbuf", 32'(TXbuffer), 32'h00);
    repeat (3) tick();
    RST = 1'b0;
    repeat (30) tick();
    check("midrst_queues", exp_step_q.size() + exp_tx_q.size(), 32'd0);
    scenario_s_1234();

    // bytes arriving mid-sequence are dropped
    do_s();
    send_byte(8'h73);
    send_byte(8'h64);
    send_byte(8'h6E);
    send_byte(8'h72);
    wait_done();

    // count boundaries, including 'h' as a count byte
    do_n(8'd255);
    wait_done();
    do_n(8'h68);
    wait_done();

    // randomized commands
    for (int it = 0; it < 25; it++) begin
      probe_base = 16'($urandom);
      case ($urandom_range(0, 6))
        0: do_s();
        1: do_d();
        2: do_n(8'($urandom_range(1, 9)));
        3: begin
          do b = 8'($urandom_range(0, 255));
          while (b == 8'h73 || b == 8'h64 || b == 8'h6E || b == 8'h72);
          send_byte(b);
        end
        4: send_byte(8'h68);
        5: do_run($urandom_range(1, 70));
        default: do_n(8'd0);
      endcase
      wait_done();
    end

    repeat (20) tick();
    check("final_queues", exp_step_q.size() + exp_tx_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
